// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC array output sequencer.
// No logic, so no latency.
// No flow control at this level; the sequencer and its FIFO own backpressure.
package mac_pkg;

    localparam int N_LANE_DEF     = 64;
    localparam int W_LANE_DEF     = 64;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        F_DONE = 2'd2,
        DONE   = 2'd3
    } mac_seq_state;

    typedef struct packed {
        logic last_mismatch;
        logic start_busy;
        logic valid_idle;
        logic skew_timeout;
    } mac_seq_exception;

endpackage

// File: rtl/mac_ofm_fifo.sv
// Synchronous FIFO holding gathered OFM beats; registered head, no bypass path.
// Latency: push becomes visible at the head one cycle later.
// Backpressure: a push is accepted when not full, or when full and popping in the same cycle.
module mac_ofm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full     = (count == DEPTH_C);
        empty    = (count == '0);
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        head_dat = mem[rd_ptr];
    end

    // Storage is not reset: contents are only observable once count is non-zero.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_array_sequencer.sv
// Gathers per-lane OFM beats from the MAC array into wide words and sequences a job to completion.
// Latency: gathered beat appears on o_ofm_valid one cycle after the lane handshake.
// Backpressure: o_lane_ofm_ready drops while the output FIFO is full; lanes hold until all enabled lanes are valid.
module mac_array_sequencer
    import mac_pkg::*;
#(
    parameter int N_LANE     = N_LANE_DEF,
    parameter int W_LANE     = W_LANE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = 255
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [N_LANE-1:0]          i_lane_mask,
    input  logic                       i_feeder_done,
    output logic                       o_busy,
    output logic                       o_done,
    input  logic [N_LANE-1:0]          i_lane_ofm_valid,
    input  logic [N_LANE*W_LANE-1:0]   i_lane_ofm_data,
    input  logic [N_LANE-1:0]          i_lane_ofm_last,
    output logic                       o_lane_ofm_ready,
    input  logic                       i_ofm_ready,
    output logic                       o_ofm_valid,
    output logic [N_LANE*W_LANE-1:0]   o_ofm_data,
    output logic                       o_ofm_last,
    output logic [15:0]                o_ofm_count,
    output logic [3:0]                 o_exceptions
);

    localparam int          DW       = N_LANE * W_LANE;
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] SKEW_MAX = 16'(TIMEOUT);
    localparam logic [15:0] SKEW_LIM = 16'(TIMEOUT - 1);

    mac_seq_state     state_q, state_d;
    mac_seq_exception exc_q;
    logic [N_LANE-1:0] mask_q;
    logic [15:0]       skew_cnt_q;
    logic [15:0]       count_q;
    logic              last_seen_q;

    logic          active, start_ok, all_valid, skew, push, pop, push_last;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [DW-1:0] push_dat;
    logic [DW:0]   head_dat;

    always_comb begin
        active           = (state_q == RUN) || (state_q == F_DONE);
        start_ok         = (state_q == IDLE) && i_start;
        all_valid        = active && (&(i_lane_ofm_valid | ~mask_q));
        o_lane_ofm_ready = active && !fifo_full;
        push             = all_valid && o_lane_ofm_ready;
        pop              = !fifo_empty && i_ofm_ready;
        skew             = active && (|(i_lane_ofm_valid & mask_q)) && !all_valid;
        push_last        = |(i_lane_ofm_last & mask_q);
    end

    // Disabled lanes are forced to zero so downstream never sees stale lane data.
    always_comb begin
        push_dat = '0;
        for (int i = 0; i < N_LANE; i++) begin
            push_dat[W_LANE*i +: W_LANE] = mask_q[i] ? i_lane_ofm_data[W_LANE*i +: W_LANE] : '0;
        end
    end

    mac_ofm_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .push     (push),
        .push_dat ({push_last, push_dat}),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (i_feeder_done) state_d = F_DONE;
            F_DONE:  if (last_seen_q && (fifo_count == '0)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy                   = (state_q != IDLE);
        o_done                   = (state_q == DONE);
        o_ofm_valid              = !fifo_empty;
        {o_ofm_last, o_ofm_data} = head_dat;
        o_ofm_count              = count_q;
        o_exceptions             = exc_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            skew_cnt_q  <= '0;
            count_q     <= '0;
            last_seen_q <= 1'b0;
            exc_q       <= '0;
        end else begin
            state_q <= state_d;
            if (skew) begin
                skew_cnt_q <= (skew_cnt_q >= SKEW_MAX) ? skew_cnt_q : skew_cnt_q + 16'd1;
            end else begin
                skew_cnt_q <= '0;
            end
            if (start_ok) begin
                mask_q      <= i_lane_mask;
                count_q     <= '0;
                last_seen_q <= 1'b0;
                exc_q       <= '0;
            end else begin
                if (pop && (count_q != 16'hFFFF)) begin
                    count_q <= count_q + 16'd1;
                end
                if (pop && o_ofm_last && active) begin
                    last_seen_q <= 1'b1;
                end
                // Flag on the cycle the counter would reach TIMEOUT.
                if (skew && (skew_cnt_q >= SKEW_LIM)) begin
                    exc_q.skew_timeout <= 1'b1;
                end
                if ((state_q == IDLE) && (|i_lane_ofm_valid)) begin
                    exc_q.valid_idle <= 1'b1;
                end
                if (i_start && (state_q != IDLE)) begin
                    exc_q.start_busy <= 1'b1;
                end
                if (push && push_last && ((i_lane_ofm_last & mask_q) != mask_q)) begin
                    exc_q.last_mismatch <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Scenario bench for mac_array_sequencer: lane driver feeds a queue of expected words, output monitor pops and compares.
// Small configuration (8 lanes x 8 bits, depth 4, timeout 20) keeps the runs short.
module tb_mac_array_sequencer;

    localparam int N     = 8;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;
    localparam int DW    = N * W;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [N-1:0]  i_lane_mask;
    logic          i_feeder_done;
    logic          o_busy;
    logic          o_done;
    logic [N-1:0]  lane_vld;
    logic [DW-1:0] lane_dat;
    logic [N-1:0]  lane_last;
    logic          o_lane_ofm_ready;
    logic          i_ofm_ready;
    logic          o_ofm_valid;
    logic [DW-1:0] o_ofm_data;
    logic          o_ofm_last;
    logic [15:0]   o_ofm_count;
    logic [3:0]    o_exceptions;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt, done_cyc, pop_cnt, push_cnt, last_pop_cyc, first_pop_cyc, any_pop_cyc;
    logic [DW-1:0] last_pop_dat;
    logic          last_pop_last;
    logic [N-1:0]  mask_cur;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   mon_e;
    bit            sender_done;

    always #5 clk = ~clk;

    mac_array_sequencer #(
        .N_LANE     (N),
        .W_LANE     (W),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .i_lane_mask      (i_lane_mask),
        .i_feeder_done    (i_feeder_done),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .i_lane_ofm_valid (lane_vld),
        .i_lane_ofm_data  (lane_dat),
        .i_lane_ofm_last  (lane_last),
        .o_lane_ofm_ready (o_lane_ofm_ready),
        .i_ofm_ready      (i_ofm_ready),
        .o_ofm_valid      (o_ofm_valid),
        .o_ofm_data       (o_ofm_data),
        .o_ofm_last       (o_ofm_last),
        .o_ofm_count      (o_ofm_count),
        .o_exceptions     (o_exceptions)
    );

    // Output monitor: every pop must match the oldest expected word.
    always @(negedge clk) begin
        cyc++;
        if (i_reset === 1'b1 && o_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (i_reset === 1'b1 && o_ofm_valid === 1'b1 && i_ofm_ready === 1'b1) begin
            if (pop_cnt == 0) first_pop_cyc = cyc;
            pop_cnt++;
            any_pop_cyc   = cyc;
            last_pop_dat  = o_ofm_data;
            last_pop_last = o_ofm_last;
            if (o_ofm_last) last_pop_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got=%h with no expected beat queued", {o_ofm_last, o_ofm_data});
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_ofm_last, o_ofm_data} !== mon_e) begin
                    failures++;
                    $display("FAIL pop_data got=%h exp=%h", {o_ofm_last, o_ofm_data}, mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rnd_dat();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] masked(input logic [DW-1:0] d, input logic [N-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[W*i +: W] = m[i] ? d[W*i +: W] : '0;
        return r;
    endfunction

    task automatic init_counts();
        done_cnt = 0; pop_cnt = 0; push_cnt = 0;
        last_pop_cyc = 0; first_pop_cyc = 0; any_pop_cyc = 0; done_cyc = 0;
    endtask

    task automatic start_job(input logic [N-1:0] m);
        i_start = 1'b1; i_lane_mask = m; mask_cur = m;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Drive one beat on the enabled lanes and hold it until the broadcast ready.
    task automatic send_beat(input logic [DW-1:0] dat, input logic [N-1:0] last, input logic fd);
        int waited;
        bit ok;
        waited = 0; ok = 0;
        lane_vld = mask_cur; lane_dat = dat; lane_last = last; i_feeder_done = fd;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (o_lane_ofm_ready === 1'b1) ok = 1; else waited++;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL lane_handshake got=no ready exp=ready within 200 cycles");
        end else begin
            #1;
            exp_q.push_back({|(last & mask_cur), masked(dat, mask_cur)});
            push_cnt++;
        end
        @(posedge clk); #1;
        lane_vld = '0; lane_last = '0; i_feeder_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL job_complete got=busy exp=idle within %0d cycles", budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b1;
        checks += 6;
        if (o_busy !== 1'b0)           begin failures++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        if (o_done !== 1'b0)           begin failures++; $display("FAIL rst_done got=%b exp=0", o_done); end
        if (o_ofm_valid !== 1'b0)      begin failures++; $display("FAIL rst_valid got=%b exp=0", o_ofm_valid); end
        if (o_lane_ofm_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", o_lane_ofm_ready); end
        if (o_ofm_count !== 16'd0)     begin failures++; $display("FAIL rst_count got=%0d exp=0", o_ofm_count); end
        if (o_exceptions !== 4'd0)     begin failures++; $display("FAIL rst_exc got=%b exp=0000", o_exceptions); end
    endtask

    task automatic test_basic();
        i_ofm_ready = 1'b1;
        init_counts();
        start_job(8'hFF);
        for (int b = 1; b <= 8; b++) send_beat(rnd_dat(), (b == 8) ? 8'hFF : 8'h00, b == 4);
        wait_idle(50);
        checks += 4;
        if (o_ofm_count !== 16'd8)          begin failures++; $display("FAIL basic_count got=%0d exp=8", o_ofm_count); end
        if (done_cnt != 1)                  begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        if (done_cyc - last_pop_cyc != 2)   begin failures++; $display("FAIL basic_done_delay got=%0d exp=2", done_cyc - last_pop_cyc); end
        if (exp_q.size() != 0)              begin failures++; $display("FAIL basic_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int n;
        i_ofm_ready = 1'b0;
        init_counts();
        sender_done = 0;
        start_job(8'hFF);
        fork
            begin
                for (int b = 1; b <= 12; b++) send_beat(rnd_dat(), (b == 12) ? 8'hFF : 8'h00, b == 1);
                sender_done = 1;
            end
        join_none
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (push_cnt != DEPTH)           begin failures++; $display("FAIL bp_pushes got=%0d exp=%0d", push_cnt, DEPTH); end
        if (o_lane_ofm_ready !== 1'b0)   begin failures++; $display("FAIL bp_ready got=%b exp=0", o_lane_ofm_ready); end
        @(posedge clk); #1;
        i_ofm_ready = 1'b1;
        n = 0;
        while (!sender_done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        wait_idle(50);
        checks += 4;
        if (pop_cnt != 12)                       begin failures++; $display("FAIL bp_pops got=%0d exp=12", pop_cnt); end
        if (o_ofm_count !== 16'd12)              begin failures++; $display("FAIL bp_count got=%0d exp=12", o_ofm_count); end
        if (any_pop_cyc - first_pop_cyc != 11)   begin failures++; $display("FAIL bp_throughput got=%0d exp=11 cycles", any_pop_cyc - first_pop_cyc); end
        if (done_cnt != 1)                       begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_mask();
        logic [DW-1:0] a5;
        logic [DW-1:0] want;
        a5   = {8{8'hA5}};
        want = 64'h00000000_A5A5A5A5;
        i_ofm_ready = 1'b1;
        init_counts();
        start_job(8'h0F);
        for (int b = 1; b <= 3; b++) send_beat(a5, (b == 3) ? 8'h0F : 8'h00, b == 1);
        wait_idle(50);
        checks += 3;
        if (last_pop_dat !== want)  begin failures++; $display("FAIL mask_data got=%h exp=%h", last_pop_dat, want); end
        if (o_ofm_count !== 16'd3)  begin failures++; $display("FAIL mask_count got=%0d exp=3", o_ofm_count); end
        if (done_cnt != 1)          begin failures++; $display("FAIL mask_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_skew();
        i_ofm_ready = 1'b1;
        init_counts();
        start_job(8'hFF);
        lane_dat = rnd_dat();
        lane_vld = 8'hDF;
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_exceptions[0] !== 1'b0) begin failures++; $display("FAIL skew_early got=%b exp=0", o_exceptions[0]); end
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (o_exceptions[0] !== 1'b1) begin failures++; $display("FAIL skew_timeout got=%b exp=1", o_exceptions[0]); end
        if (o_ofm_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL skew_no_push got=%b exp=0", o_ofm_valid); end
        @(posedge clk); #1;
        lane_vld = '0;
        repeat (5) @(posedge clk);
        #1;
        send_beat(rnd_dat(), 8'hFF, 1'b1);
        wait_idle(50);
        checks += 2;
        if (o_exceptions !== 4'b0001) begin failures++; $display("FAIL skew_sticky got=%b exp=0001", o_exceptions); end
        if (done_cnt != 1)            begin failures++; $display("FAIL skew_done_pulses got=%0d exp=1", done_cnt); end
        start_job(8'hFF);
        checks++;
        if (o_exceptions !== 4'b0000) begin failures++; $display("FAIL start_clears_exc got=%b exp=0000", o_exceptions); end
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        checks += 2;
        if (o_exceptions !== 4'b0100) begin failures++; $display("FAIL start_busy got=%b exp=0100", o_exceptions); end
        if (o_busy !== 1'b1)          begin failures++; $display("FAIL start_busy_ignored got=%b exp=1", o_busy); end
        send_beat(rnd_dat(), 8'hFF, 1'b1);
        wait_idle(50);
    endtask

    task automatic test_last_mismatch();
        i_ofm_ready = 1'b1;
        init_counts();
        start_job(8'hFF);
        send_beat(rnd_dat(), 8'h00, 1'b1);
        send_beat(rnd_dat(), 8'h01, 1'b0);
        wait_idle(50);
        checks += 4;
        if (o_exceptions !== 4'b1000) begin failures++; $display("FAIL mismatch_exc got=%b exp=1000", o_exceptions); end
        if (last_pop_last !== 1'b1)   begin failures++; $display("FAIL mismatch_last got=%b exp=1", last_pop_last); end
        if (done_cnt != 1)            begin failures++; $display("FAIL mismatch_done_pulses got=%0d exp=1", done_cnt); end
        if (o_ofm_count !== 16'd2)    begin failures++; $display("FAIL mismatch_count got=%0d exp=2", o_ofm_count); end
    endtask

    task automatic test_reset_mid();
        i_ofm_ready = 1'b0;
        init_counts();
        start_job(8'hFF);
        for (int b = 1; b <= 3; b++) send_beat(rnd_dat(), 8'h00, 1'b0);
        checks++;
        if (o_ofm_valid !== 1'b1) begin failures++; $display("FAIL rmid_queued got=%b exp=1", o_ofm_valid); end
        i_reset = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b1;
        exp_q.delete();
        checks += 4;
        if (o_ofm_valid !== 1'b0)      begin failures++; $display("FAIL rmid_valid got=%b exp=0", o_ofm_valid); end
        if (o_busy !== 1'b0)           begin failures++; $display("FAIL rmid_idle got=%b exp=0", o_busy); end
        if (o_lane_ofm_ready !== 1'b0) begin failures++; $display("FAIL rmid_ready got=%b exp=0", o_lane_ofm_ready); end
        if (o_ofm_count !== 16'd0)     begin failures++; $display("FAIL rmid_count got=%0d exp=0", o_ofm_count); end
        lane_vld = 8'hFF;
        @(posedge clk); #1;
        lane_vld = '0;
        checks += 2;
        if (o_exceptions !== 4'b0010) begin failures++; $display("FAIL valid_idle got=%b exp=0010", o_exceptions); end
        if (done_cnt != 0)            begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", done_cnt); end
        i_ofm_ready = 1'b1;
        init_counts();
        start_job(8'hFF);
        send_beat(rnd_dat(), 8'h00, 1'b1);
        send_beat(rnd_dat(), 8'hFF, 1'b0);
        wait_idle(50);
        checks += 3;
        if (o_ofm_count !== 16'd2)    begin failures++; $display("FAIL rmid_restart_count got=%0d exp=2", o_ofm_count); end
        if (done_cnt != 1)            begin failures++; $display("FAIL rmid_restart_done got=%0d exp=1", done_cnt); end
        if (o_exceptions !== 4'b0000) begin failures++; $display("FAIL rmid_restart_exc got=%b exp=0000", o_exceptions); end
    endtask

    initial begin
        i_reset = 1'b0; i_start = 1'b0; i_lane_mask = '0; i_feeder_done = 1'b0;
        lane_vld = '0; lane_dat = '0; lane_last = '0; i_ofm_ready = 1'b0; mask_cur = '0;
        init_counts();
        test_reset();
        test_basic();
        test_backpressure();
        test_mask();
        test_skew();
        test_last_mismatch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
